// File: rtl/adder_pkg.sv
// Shared constants for the registered N-bit adder and its toggle counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_pkg;

    localparam int ADDER_N     = 22;
    localparam int ADDER_CNT_W = 32;

    // Width needed to hold the popcount of an (n+1)-bit vector (0..n+1).
    function automatic int popcount_w(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/adder_popcount.sv
// Combinational population count of a W-bit vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: vec (W bits in), count ($clog2(W+1) bits out, number of ones in vec).
module adder_popcount #(
    parameter int W  = 23,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  vec,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(vec[i]);
        end
    end

endmodule

// File: rtl/adder_n.sv
// Registered N-bit unsigned adder: {carry_out, sum} = input1 + input2.
// Latency: 1 cycle, throughput 1 result per cycle, outputs come straight from flops.
// Backpressure: none; every in_valid cycle is accepted.
// Ports: clk, rst (sync, active-high), in_valid, input1/input2 (N bits),
//        sum (N bits), carry_out, out_valid, toggle_count (CNT_W bits, optional).
// Optional feature: define ADDER_TOGGLE_CNT_EN to add the output-toggle counter.
module adder_n
    import adder_pkg::*;
#(
    parameter int N = ADDER_N
`ifdef ADDER_TOGGLE_CNT_EN
    ,
    parameter int CNT_W = ADDER_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N-1:0]     input1,
    input  logic [N-1:0]     input2,
    output logic [N-1:0]     sum,
    output logic             carry_out,
    output logic             out_valid
`ifdef ADDER_TOGGLE_CNT_EN
    ,
    output logic [CNT_W-1:0] toggle_count
`endif
);

    // Zero-extend so the carry falls out of the behavioural add.
    logic [N:0] full_sum;
    assign full_sum = {1'b0, input1} + {1'b0, input2};

    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            carry_out <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                {carry_out, sum} <= full_sum;
            end
        end
    end

`ifdef ADDER_TOGGLE_CNT_EN
    localparam int PW = popcount_w(N);

    logic [PW-1:0]  flips;
    logic [CNT_W:0] cnt_next;

    // Bits that will change on this load: old registered result vs new one.
    adder_popcount #(
        .W  (N + 1),
        .CW (PW)
    ) u_popcount (
        .vec   ({carry_out, sum} ^ full_sum),
        .count (flips)
    );

    // One extra bit catches overflow so the counter can clamp instead of wrap.
    assign cnt_next = {1'b0, toggle_count} + (CNT_W + 1)'(flips);

    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_count <= '0;
        end else if (in_valid) begin
            toggle_count <= cnt_next[CNT_W] ? {CNT_W{1'b1}} : cnt_next[CNT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_adder_n.sv
module tb_adder_n;

    localparam int N = 22;
    localparam logic [N-1:0] ONES = {N{1'b1}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [N-1:0] input1 = '0;
    logic [N-1:0] input2 = '0;
    logic [N-1:0] sum;
    logic         carry_out;
    logic         out_valid;
`ifdef ADDER_TOGGLE_CNT_EN
    logic [31:0]  toggle_count;
    logic [5:0]   toggle_sat;
    logic [N-1:0] sum_s;
    logic         carry_s;
    logic         valid_s;
`endif

    always #5 clk = ~clk;

    adder_n #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .input1       (input1),
        .input2       (input2),
        .sum          (sum),
        .carry_out    (carry_out),
        .out_valid    (out_valid)
`ifdef ADDER_TOGGLE_CNT_EN
        ,
        .toggle_count (toggle_count)
`endif
    );

`ifdef ADDER_TOGGLE_CNT_EN
    // Narrow counter instance so saturation is reachable in a few loads.
    adder_n #(.N(N), .CNT_W(6)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .input1       (input1),
        .input2       (input2),
        .sum          (sum_s),
        .carry_out    (carry_s),
        .out_valid    (valid_s),
        .toggle_count (toggle_sat)
    );
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arithmetic on wide integers, updated at each rising edge.
    logic [N-1:0] m_sum = '0;
    logic         m_c   = 1'b0;
    logic         m_v   = 1'b0;
    longint       m_tc  = 0;
    longint       m_tcs = 0;

    always @(posedge clk) begin
        longint       s;
        logic [N:0]   nv;
        int           flips;
        if (rst) begin
            m_sum = '0; m_c = 1'b0; m_v = 1'b0; m_tc = 0; m_tcs = 0;
        end else begin
            m_v = in_valid;
            if (in_valid) begin
                s     = longint'(input1) + longint'(input2);
                nv    = s[N:0];
                flips = $countones(nv ^ {m_c, m_sum});
                m_tc  = (m_tc + flips > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_tc + flips;
                m_tcs = (m_tcs + flips > 63) ? 63 : m_tcs + flips;
                m_sum = s[N-1:0];
                m_c   = s[N];
            end
        end
    end

    // Compare process: outputs are always meaningful (held when idle).
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_sum", longint'(sum), longint'(m_sum));
            chk("cyc_carry", longint'(carry_out), longint'(m_c));
            chk("cyc_valid", longint'(out_valid), longint'(m_v));
`ifdef ADDER_TOGGLE_CNT_EN
            chk("cyc_toggle", longint'(toggle_count), m_tc);
            chk("cyc_toggle_sat", longint'(toggle_sat), m_tcs);
`endif
        end
    end

    task automatic drive(input bit r, input bit v, input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        input1   = a;
        input2   = b;
    endtask

    // Let the next edge land, then sample just after it.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [43:0] pattern(input int i);
        logic [43:0] p;
        case (i)
            0: p = '0;
            1: p = '1;
            2: p = {22{2'b01}};
            3: p = {22{2'b10}};
            default: begin
                p = 44'h1;
                p = (p << (2 * i)) - 44'h1;
            end
        endcase
        return p;
    endfunction

    function automatic logic [N-1:0] rand_op();
        logic [N-1:0] r;
        r = N'($urandom);
        case ($urandom_range(0, 7))
            0: r = '0;
            1: r = ONES;
            2: r = N'(1);
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        logic [43:0] p;
        int          idx;

        // Reset with live operands: reset must win.
        drive(1'b1, 1'b1, ONES, ONES);
        drive(1'b1, 1'b1, ONES, N'(5));
        settle();
        chk_en = 1'b1;
        chk("rst_sum", longint'(sum), 0);
        chk("rst_carry", longint'(carry_out), 0);
        chk("rst_valid", longint'(out_valid), 0);
`ifdef ADDER_TOGGLE_CNT_EN
        chk("rst_toggle", longint'(toggle_count), 0);
`endif

        // All-ones + all-ones from reset: {1, 3FFFFE}, 22 bits flip.
        drive(1'b0, 1'b1, ONES, ONES);
        settle();
        chk("ones_sum", longint'(sum), 64'h3FFFFE);
        chk("ones_carry", longint'(carry_out), 1);
        chk("ones_valid", longint'(out_valid), 1);
`ifdef ADDER_TOGGLE_CNT_EN
        chk("toggle_22", longint'(toggle_count), 22);
`endif
        drive(1'b0, 1'b1, '0, '0);
        settle();
        chk("zero_sum", longint'(sum), 0);
`ifdef ADDER_TOGGLE_CNT_EN
        chk("toggle_44", longint'(toggle_count), 44);
        drive(1'b0, 1'b1, ONES, ONES);
        settle();
        chk("toggle_66", longint'(toggle_count), 66);
        chk("sat_63", longint'(toggle_sat), 63);
        drive(1'b0, 1'b1, '0, '0);
        settle();
        chk("toggle_88", longint'(toggle_count), 88);
        chk("sat_nowrap", longint'(toggle_sat), 63);
`endif

        // Basic add and carry/wrap cases.
        drive(1'b0, 1'b1, '0, 22'h3FFFFC);
        settle();
        chk("basic_sum", longint'(sum), 64'h3FFFFC);
        chk("basic_carry", longint'(carry_out), 0);
        chk("basic_valid", longint'(out_valid), 1);
        drive(1'b0, 1'b1, 22'h3FFFF0, 22'h3FFFFF);
        settle();
        chk("wrap1_sum", longint'(sum), 64'h3FFFEF);
        chk("wrap1_carry", longint'(carry_out), 1);
        drive(1'b0, 1'b1, 22'h3FFFFF, 22'h000001);
        settle();
        chk("wrap2_sum", longint'(sum), 0);
        chk("wrap2_carry", longint'(carry_out), 1);

        // Hold: idle cycles with changing operands leave the result alone.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, N'($urandom) | N'(1), ONES);
            settle();
            chk("hold_sum", longint'(sum), 0);
            chk("hold_carry", longint'(carry_out), 1);
            chk("hold_valid", longint'(out_valid), 0);
        end

        // Back-to-back bursts over the pattern set.
        idx = 0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 20; c++) begin
                p = pattern(idx);
                drive(1'b0, 1'b1, p[21:0], p[43:22]);
                idx = (idx + 1) % 22;
            end
            for (int c = 0; c < 7; c++) begin
                drive(1'b0, 1'b0, N'($urandom), N'($urandom));
            end
        end

        // Random traffic with sporadic mid-stream resets.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), rand_op(), rand_op());
        end

        drive(1'b0, 1'b0, '0, '0);
        settle();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
